exe_result_buf: RTL and testbench
=================================

EXE_RESULT_BUF -- requirements
Module: exe_result_buf

Interface
REQ-001 The block SHALL have parameters: PC_SZ, default 32, program-counter width; RSZ, default 32, register data width; GPR_ASZ, default 5, register address width.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- exe_valid  in  1  functional-unit result valid.
- exe_ready  out  1  buffer can accept a result.
- exe_res  in  exe_res_t  result record: pc, rd_wr, rd_addr, rd_data, mem_op (NONE/LOAD/STORE), ls_size (2b), st_data.
- mem_valid  out  1  head entry valid toward MEM stage.
- mem_ready  in  1  MEM stage accepts head.
- mem_res  out  exe_res_t  head entry record.
- flush  in  1  discard all buffered results.
- fwd_addr  in  GPR_ASZ  operand address to bypass.
- fwd_hit  out  1  a buffered entry supplies fwd_addr.
- fwd_data  out  RSZ  bypass data.
- occ  out  2  current occupancy, 0..2.

Function
REQ-003 The block SHALL be a 2-entry in-order FIFO between the ALU/MUL/DIV functional units and the MEM stage.
REQ-004 Push SHALL occur on a rising edge when exe_valid && exe_ready.
REQ-005 Pop SHALL occur on a rising edge when mem_valid && mem_ready.
REQ-006 exe_ready SHALL equal (occ < 2), derived only from registered state with no combinational path from mem_ready.
REQ-007 mem_valid SHALL equal (occ != 0), and mem_res SHALL present the oldest entry.
REQ-008 A pushed record SHALL appear on mem_res one cycle after the push edge when the buffer was empty (latency 1).
REQ-009 For simultaneous push and pop at occ=1, occ SHALL stay 1 and the new entry SHALL become head on the next cycle.
REQ-010 Push at occ=2 cannot occur (exe_ready=0). Pop at occ=0 SHALL be ignored.
REQ-011 Read and write pointers SHALL be 1 bit each, wrapping 1->0.
REQ-012 occ SHALL update as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-013 flush SHALL take priority over push and pop.
REQ-014 A flush SHALL set occ=0 and both pointers to 0 on the next edge, and a concurrent push SHALL be dropped.
REQ-015 fwd_hit SHALL be combinational: 1 iff some valid entry has rd_wr=1, rd_addr==fwd_addr and rd_addr!=0.
REQ-016 fwd_data SHALL come from the youngest matching entry, and SHALL be 0 when fwd_hit=0.
REQ-017 Entries with mem_op=LOAD SHALL NOT produce fwd_hit, because their rd_data is not final.
REQ-018 mem_res and all other outputs SHALL hold their value while mem_valid && !mem_ready (stall stability).

Reset
REQ-019 On reset assertion, without waiting for clk: occ=0, pointers=0, all entry storage=0, mem_valid=0, exe_ready=1 (once reset releases), fwd_hit=0, mem_res=all zeros.
REQ-020 While reset=1, exe_ready SHALL be 0, and no push SHALL occur.
REQ-021 Reset asserted mid-operation SHALL discard all entries irrespective of flush, exe_valid or mem_ready.

Structure
REQ-022 exe_res_t and the mem_op enum (MOP_NONE=0, MOP_LOAD=1, MOP_STORE=2) SHALL reside in cpu_structs_pkg.
REQ-023 PC_SZ, RSZ and GPR_ASZ SHALL come from cpu_params_pkg.
REQ-024 The storage/pointer logic SHALL be one sub-module, res_fifo2, parameterised on the record type. The top level SHALL add forwarding and the port mapping.
REQ-025 The block SHALL use no latches, and only the reset port SHALL be asynchronous.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single pass: push {pc=0x100, rd=5, data=0xDEADBEEF} with mem_ready=1 -> mem_valid next cycle with same record, occ 1 then 0.
- Fill/stall: mem_ready=0, push pc=0x200 then 0x204 -> occ=2, exe_ready=0; a third exe_valid is not accepted; mem_ready=1 -> 0x200 then 0x204, in order.
- Simultaneous push/pop at occ=1 -> occ stays 1, and the head advances to the new pc.
- Forwarding: entries rd=7 data=0x11 (older) and rd=7 data=0x22 (younger), fwd_addr=7 -> fwd_hit=1, fwd_data=0x22; fwd_addr=0 -> fwd_hit=0; a LOAD entry to rd=9 with fwd_addr=9 -> fwd_hit=0.
- Flush with concurrent push at occ=2 -> next cycle occ=0, mem_valid=0, and the pushed record never appears.
- Async reset asserted mid-cycle at occ=2 -> mem_valid=0 and occ=0 immediately; after release exe_ready=1.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// Global CPU sizing constants shared by the pipeline blocks.
package cpu_params_pkg;
   localparam int PC_SZ   = 32;
   localparam int RSZ     = 32;
   localparam int GPR_ASZ = 5;
endpackage

// File: rtl/cpu_structs_pkg.sv
// Record types passed between pipeline stages, plus the bypass match helper.
package cpu_structs_pkg;
   import cpu_params_pkg::*;

   typedef enum logic [1:0] {
      MOP_NONE  = 2'd0,
      MOP_LOAD  = 2'd1,
      MOP_STORE = 2'd2
   } mem_op_e;

   typedef struct packed {
      logic [PC_SZ-1:0]   pc;
      logic               rd_wr;
      logic [GPR_ASZ-1:0] rd_addr;
      logic [RSZ-1:0]     rd_data;
      mem_op_e            mem_op;
      logic [1:0]         ls_size;
      logic [RSZ-1:0]     st_data;
   } exe_res_t;

   // Loads are excluded: their rd_data is only known after the MEM stage.
   function automatic logic fwd_match(input exe_res_t e, input logic [GPR_ASZ-1:0] addr);
      return e.rd_wr && (e.mem_op != MOP_LOAD) && (e.rd_addr == addr) && (addr != '0);
   endfunction
endpackage

// File: rtl/exe_result_buf_if.sv
// Handshake and bypass signals between the functional units, the result buffer and MEM.
interface exe_result_buf_if
   import cpu_structs_pkg::*;
#(
   parameter int RSZ     = cpu_params_pkg::RSZ,
   parameter int GPR_ASZ = cpu_params_pkg::GPR_ASZ
);
   logic               exe_valid;
   logic               exe_ready;
   exe_res_t           exe_res;
   logic               mem_valid;
   logic               mem_ready;
   exe_res_t           mem_res;
   logic               flush;
   logic [GPR_ASZ-1:0] fwd_addr;
   logic               fwd_hit;
   logic [RSZ-1:0]     fwd_data;
   logic [1:0]         occ;

   modport slave (
      input  exe_valid, exe_res, mem_ready, flush, fwd_addr,
      output exe_ready, mem_valid, mem_res, fwd_hit, fwd_data, occ
   );

   modport master (
      output exe_valid, exe_res, mem_ready, flush, fwd_addr,
      input  exe_ready, mem_valid, mem_res, fwd_hit, fwd_data, occ
   );
endinterface

// File: rtl/res_fifo2.sv
// Two-entry in-order FIFO of an arbitrary packed record; exposes both slots for bypassing.
module res_fifo2 #(
   parameter type T = logic [7:0]
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       flush_i,
   input  T           wdata_i,
   output T           head_o,
   output T           next_o,
   output logic [1:0] occ_o
);
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] occ_q, occ_d;
   logic       push, pop;
   logic [1:0] we;
   T           mem_q [2];

   always_comb begin
      push     = push_i && (occ_q != 2'd2);
      pop      = pop_i && (occ_q != 2'd0);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      we       = '0;
      // Flush wins over everything, including a push arriving in the same cycle.
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         occ_d    = 2'd0;
      end else begin
         if (push) begin
            we[wr_ptr_q] = 1'b1;
            wr_ptr_d     = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mem_q[gi] <= '0;
         end else if (we[gi]) begin
            mem_q[gi] <= wdata_i;
         end
      end
   end

   // With two slots the younger entry always sits opposite the read pointer.
   assign head_o = mem_q[rd_ptr_q];
   assign next_o = mem_q[~rd_ptr_q];
   assign occ_o  = occ_q;
endmodule

// File: rtl/exe_result_buf.sv
// Execute-result buffer: 2-deep FIFO toward MEM with register bypass from buffered results.
module exe_result_buf
   import cpu_structs_pkg::*;
#(
   parameter int PC_SZ   = cpu_params_pkg::PC_SZ,
   parameter int RSZ     = cpu_params_pkg::RSZ,
   parameter int GPR_ASZ = cpu_params_pkg::GPR_ASZ
) (
   input  logic             clk,
   input  logic             reset,
   exe_result_buf_if.slave  bus
);
   if ($bits(exe_res_t) != PC_SZ + 1 + GPR_ASZ + 2 * RSZ + 4) begin : g_cfg_err
      $error("exe_result_buf parameters disagree with exe_res_t layout");
   end

   exe_res_t   head, next;
   logic [1:0] occ;
   logic       old_hit, young_hit;

   res_fifo2 #(.T(exe_res_t)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.exe_valid),
      .pop_i   (bus.mem_ready),
      .flush_i (bus.flush),
      .wdata_i (bus.exe_res),
      .head_o  (head),
      .next_o  (next),
      .occ_o   (occ)
   );

   // Ready depends only on state and reset, never on mem_ready.
   assign bus.exe_ready = !reset && (occ != 2'd2);
   assign bus.mem_valid = (occ != 2'd0);
   assign bus.mem_res   = head;
   assign bus.occ       = occ;

   always_comb begin
      old_hit   = (occ != 2'd0) && fwd_match(head, bus.fwd_addr);
      young_hit = (occ == 2'd2) && fwd_match(next, bus.fwd_addr);
      bus.fwd_hit  = old_hit || young_hit;
      bus.fwd_data = '0;
      if (young_hit) begin
         bus.fwd_data = next.rd_data;
      end else if (old_hit) begin
         bus.fwd_data = head.rd_data;
      end
   end
endmodule

// File: tb/tb_exe_result_buf.sv
// Directed bench for exe_result_buf: handshake, ordering, bypass, flush and async reset.
module tb_exe_result_buf;
   import cpu_structs_pkg::*;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   exe_result_buf_if bus ();

   exe_result_buf dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   function automatic exe_res_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [31:0] data, input mem_op_e op);
      exe_res_t r;
      r         = '0;
      r.pc      = pc;
      r.rd_wr   = 1'b1;
      r.rd_addr = rd;
      r.rd_data = data;
      r.mem_op  = op;
      r.ls_size = 2'd2;
      r.st_data = 32'hA5A5_0000 | pc;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input exe_res_t r);
      bus.exe_valid = 1'b1;
      bus.exe_res   = r;
      tick();
      bus.exe_valid = 1'b0;
      #1;
   endtask

   exe_res_t r1, r2;

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      reset         = 1'b1;
      bus.exe_valid = 1'b0;
      bus.exe_res   = '0;
      bus.mem_ready = 1'b0;
      bus.flush     = 1'b0;
      bus.fwd_addr  = '0;
      #3;
      check("rst_exe_ready", 128'(bus.exe_ready), 128'(0));
      check("rst_mem_valid", 128'(bus.mem_valid), 128'(0));
      check("rst_occ", 128'(bus.occ), 128'(0));
      check("rst_fwd_hit", 128'(bus.fwd_hit), 128'(0));
      check("rst_mem_res", 128'(bus.mem_res), 128'(0));
      tick();
      reset = 1'b0;
      #1;
      check("rel_exe_ready", 128'(bus.exe_ready), 128'(1));

      // Single pass
      bus.mem_ready = 1'b1;
      r1 = mk(32'h100, 5'd5, 32'hDEAD_BEEF, MOP_NONE);
      push(r1);
      check("sp_mem_valid", 128'(bus.mem_valid), 128'(1));
      check("sp_mem_res", 128'(bus.mem_res), 128'(r1));
      check("sp_occ1", 128'(bus.occ), 128'(1));
      tick();
      check("sp_occ0", 128'(bus.occ), 128'(0));
      check("sp_mem_valid0", 128'(bus.mem_valid), 128'(0));

      // Fill and stall
      bus.mem_ready = 1'b0;
      push(mk(32'h200, 5'd1, 32'h1, MOP_NONE));
      push(mk(32'h204, 5'd2, 32'h2, MOP_NONE));
      check("fill_occ2", 128'(bus.occ), 128'(2));
      check("fill_exe_ready", 128'(bus.exe_ready), 128'(0));
      push(mk(32'h208, 5'd3, 32'h3, MOP_NONE));
      check("fill_third_occ", 128'(bus.occ), 128'(2));
      check("fill_stall_head", 128'(bus.mem_res.pc), 128'(32'h200));
      bus.mem_ready = 1'b1;
      #1;
      check("drain_head0", 128'(bus.mem_res.pc), 128'(32'h200));
      tick();
      check("drain_head1", 128'(bus.mem_res.pc), 128'(32'h204));
      check("drain_occ1", 128'(bus.occ), 128'(1));
      tick();
      check("drain_occ0", 128'(bus.occ), 128'(0));

      // Simultaneous push/pop at occ=1
      bus.mem_ready = 1'b0;
      push(mk(32'h300, 5'd4, 32'h4, MOP_NONE));
      bus.mem_ready = 1'b1;
      push(mk(32'h304, 5'd6, 32'h6, MOP_NONE));
      check("pp_occ", 128'(bus.occ), 128'(1));
      check("pp_head", 128'(bus.mem_res.pc), 128'(32'h304));
      tick();
      check("pp_drain_occ", 128'(bus.occ), 128'(0));

      // Forwarding
      bus.mem_ready = 1'b0;
      push(mk(32'h400, 5'd7, 32'h11, MOP_NONE));
      push(mk(32'h404, 5'd7, 32'h22, MOP_NONE));
      bus.fwd_addr = 5'd7;
      #1;
      check("fwd_hit_young", 128'(bus.fwd_hit), 128'(1));
      check("fwd_data_young", 128'(bus.fwd_data), 128'(32'h22));
      bus.fwd_addr = 5'd0;
      #1;
      check("fwd_r0_hit", 128'(bus.fwd_hit), 128'(0));
      check("fwd_r0_data", 128'(bus.fwd_data), 128'(0));
      bus.fwd_addr  = 5'd7;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      #1;
      check("fwd_head_data", 128'(bus.fwd_data), 128'(32'h22));
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      push(mk(32'h408, 5'd9, 32'h99, MOP_LOAD));
      bus.fwd_addr = 5'd9;
      #1;
      check("fwd_load_hit", 128'(bus.fwd_hit), 128'(0));
      check("fwd_load_data", 128'(bus.fwd_data), 128'(0));
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;

      // Flush with concurrent push at occ=2
      push(mk(32'h500, 5'd1, 32'h5, MOP_NONE));
      push(mk(32'h504, 5'd2, 32'h6, MOP_STORE));
      bus.flush = 1'b1;
      push(mk(32'h508, 5'd3, 32'h7, MOP_NONE));
      bus.flush = 1'b0;
      #1;
      check("fl_occ", 128'(bus.occ), 128'(0));
      check("fl_mem_valid", 128'(bus.mem_valid), 128'(0));
      check("fl_exe_ready", 128'(bus.exe_ready), 128'(1));
      r2 = mk(32'h600, 5'd8, 32'h8, MOP_NONE);
      push(r2);
      check("fl_next_head", 128'(bus.mem_res), 128'(r2));
      check("fl_next_occ", 128'(bus.occ), 128'(1));
      bus.mem_ready = 1'b1;
      tick();
      check("fl_drain_valid", 128'(bus.mem_valid), 128'(0));
      bus.mem_ready = 1'b0;

      // Async reset mid-cycle at occ=2
      push(mk(32'h700, 5'd1, 32'h1, MOP_NONE));
      push(mk(32'h704, 5'd2, 32'h2, MOP_NONE));
      check("ar_pre_occ", 128'(bus.occ), 128'(2));
      #1;
      reset = 1'b1;
      #1;
      check("ar_mem_valid", 128'(bus.mem_valid), 128'(0));
      check("ar_occ", 128'(bus.occ), 128'(0));
      check("ar_mem_res", 128'(bus.mem_res), 128'(0));
      check("ar_exe_ready", 128'(bus.exe_ready), 128'(0));
      tick();
      reset = 1'b0;
      #1;
      check("ar_rel_exe_ready", 128'(bus.exe_ready), 128'(1));
      check("ar_rel_occ", 128'(bus.occ), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
